// File: rtl/ram_sweep_reader_pkg.sv
// Shared constants for the 32x4 RAM read/write paths and the sweep reader FSM encoding.
package ram_sweep_reader_pkg;

   localparam int RAM_ADDR_W = 5;
   localparam int RAM_DATA_W = 4;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_READ    = 2'd1;
   localparam logic [1:0] ST_PRESENT = 2'd2;
   localparam logic [1:0] ST_DONE    = 2'd3;

endpackage

// File: rtl/ram_sweep_reader_wrap_addr_counter.sv
// Sweep address counter: holds the current and last address, wraps modulo 2**ADDR_W,
// and flags when the current address is the last one of the sweep.
module wrap_addr_counter #(
   parameter int ADDR_W = 5
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load_i,
   input  logic [ADDR_W-1:0] first_i,
   input  logic [ADDR_W-1:0] last_i,
   input  logic              inc_i,
   output logic [ADDR_W-1:0] cnt_o,
   output logic              at_last_o
);

   logic [ADDR_W-1:0] cur_q, cur_d;
   logic [ADDR_W-1:0] last_q, last_d;

   always_comb begin
      cur_d  = cur_q;
      last_d = last_q;
      if (load_i) begin
         cur_d  = first_i;
         last_d = last_i;
      end else if (inc_i) begin
         // natural overflow of the ADDR_W-bit sum gives the 31->0 wrap
         cur_d = cur_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cur_q  <= '0;
         last_q <= '0;
      end else begin
         cur_q  <= cur_d;
         last_q <= last_d;
      end
   end

   assign cnt_o     = cur_q;
   assign at_last_o = (cur_q == last_q);

endmodule

// File: rtl/ram_sweep_reader.sv
// Reads RAM words first_addr..last_addr (wrapping) on a start pulse and hands each
// word with its address to a consumer over valid/ready.
module ram_sweep_reader
   import ram_sweep_reader_pkg::*;
#(
   parameter int ADDR_W = RAM_ADDR_W,
   parameter int DATA_W = RAM_DATA_W,
   parameter int RD_LAT = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] first_addr,
   input  logic [ADDR_W-1:0] last_addr,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] ram_address,
   output logic              ram_wren,
   input  logic [DATA_W-1:0] ram_q,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [1:0]        dbg_state
);

   // Handshake: a word transfers on a clock edge where out_valid & out_ready are both high;
   // out_valid, out_data and out_addr are held unchanged until that edge.

   localparam int              LAT_W    = $clog2(RD_LAT + 2);
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT);

   logic [1:0]        state_q, state_d;
   logic [LAT_W-1:0]  lat_q, lat_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [ADDR_W-1:0] out_addr_q, out_addr_d;
   logic              out_valid_q, out_valid_d;

   logic              cnt_load, cnt_inc, cnt_at_last;
   logic [ADDR_W-1:0] cur_addr;

   wrap_addr_counter #(.ADDR_W(ADDR_W)) u_addr_cnt (
      .clk_i     (clock),
      .rst_i     (reset),
      .load_i    (cnt_load),
      .first_i   (first_addr),
      .last_i    (last_addr),
      .inc_i     (cnt_inc),
      .cnt_o     (cur_addr),
      .at_last_o (cnt_at_last)
   );

   always_comb begin
      state_d     = state_q;
      lat_d       = lat_q;
      out_data_d  = out_data_q;
      out_addr_d  = out_addr_q;
      out_valid_d = out_valid_q;
      cnt_load    = 1'b0;
      cnt_inc     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               cnt_load = 1'b1;
               lat_d    = '0;
               state_d  = ST_READ;
            end
         end
         ST_READ: begin
            // one edge for the RAM to register the address, RD_LAT more for q to settle
            if (lat_q == LAT_LAST) begin
               out_data_d  = ram_q;
               out_addr_d  = cur_addr;
               out_valid_d = 1'b1;
               lat_d       = '0;
               state_d     = ST_PRESENT;
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end
         ST_PRESENT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               if (cnt_at_last) begin
                  state_d = ST_DONE;
               end else begin
                  cnt_inc = 1'b1;
                  lat_d   = '0;
                  state_d = ST_READ;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         lat_q       <= '0;
         out_data_q  <= '0;
         out_addr_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         lat_q       <= lat_d;
         out_data_q  <= out_data_d;
         out_addr_q  <= out_addr_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign busy        = (state_q != ST_IDLE);
   assign done        = (state_q == ST_DONE);
   assign ram_address = cur_addr;
   assign ram_wren    = 1'b0;
   assign out_data    = out_data_q;
   assign out_addr    = out_addr_q;
   assign out_valid   = out_valid_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_ram_sweep_reader.sv
// Bench for ram_sweep_reader with a behavioural 32x4 RAM (registered address, unregistered q).
module tb_ram_sweep_reader;

   localparam int AW = 5;
   localparam int DW = 4;

   logic          clock = 1'b0;
   logic          reset;
   logic          start;
   logic [AW-1:0] first_addr;
   logic [AW-1:0] last_addr;
   logic          busy;
   logic          done;
   logic [AW-1:0] ram_address;
   logic          ram_wren;
   logic [DW-1:0] ram_q;
   logic [DW-1:0] out_data;
   logic [AW-1:0] out_addr;
   logic          out_valid;
   logic          out_ready;
   logic [1:0]    dbg_state;

   logic [DW-1:0] mem [32];
   logic [AW-1:0] ram_addr_reg = '0;

   logic [AW+DW-1:0] exp_q [$];
   int tests  = 0;
   int failed = 0;

   ram_sweep_reader #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .first_addr  (first_addr),
      .last_addr   (last_addr),
      .busy        (busy),
      .done        (done),
      .ram_address (ram_address),
      .ram_wren    (ram_wren),
      .ram_q       (ram_q),
      .out_data    (out_data),
      .out_addr    (out_addr),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .dbg_state   (dbg_state)
   );

   // clock / behavioural RAM
   always #5 clock = ~clock;

   always @(posedge clock) ram_addr_reg <= ram_address;
   assign ram_q = mem[ram_addr_reg];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Runs one sweep and scores every accepted word against the expected list.
   task automatic do_sweep(input logic [AW-1:0] f, input logic [AW-1:0] l, input int ready_pct,
                           input int stall, input bit poke_busy, input bit poke_done);
      logic [AW-1:0]    span;
      logic [AW-1:0]    a;
      logic [AW+DW-1:0] obs_w;
      logic [AW+DW-1:0] held;
      int  n, words, dones, gap, budget, stall_left;
      bit  prev_hold, poked, rdy;
      span = l - f;
      n    = int'(span) + 1;
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
         a = f + AW'(i);
         exp_q.push_back({a, mem[a]});
      end
      first_addr = f;
      last_addr  = l;
      start      = 1'b1;
      out_ready  = 1'b0;
      tick();
      start = 1'b0;
      check("busy_after_start", 32'(busy), 32'd1);
      words = 0; dones = 0; gap = 0; prev_hold = 0; poked = 0; held = '0;
      stall_left = stall;
      budget = n * 40 + 50;
      while (budget > 0) begin
         budget--;
         if (done) begin
            dones++;
            check("empty_at_done", 32'(exp_q.size()), 32'd0);
            check("busy_at_done", 32'(busy), 32'd1);
            check("valid_at_done", 32'(out_valid), 32'd0);
            if (poke_done) begin
               start      = 1'b1;
               first_addr = ~f;
               last_addr  = ~l;
            end
            tick();
            start = 1'b0;
            check("busy_after_done", 32'(busy), 32'd0);
            check("done_one_cycle", 32'(done), 32'd0);
            break;
         end
         if (out_valid) begin
            obs_w = {out_addr, out_data};
            if (prev_hold) check("hold_stable", 32'(obs_w), 32'(held));
            else           check("issue_gap", 32'(gap), 32'd2);
            check("ram_addr_tracks", 32'(ram_address), 32'(out_addr));
            check("wren_low", 32'(ram_wren), 32'd0);
            if (exp_q.size() == 0) check("extra_word", 32'(obs_w), 32'h1ff);
            else                   check("word", 32'(obs_w), 32'(exp_q[0]));
            if (stall_left > 0 && words == 0) begin
               rdy = 1'b0;
               stall_left--;
            end else begin
               rdy = ($urandom_range(0, 99) < ready_pct);
            end
            if (poke_busy && !poked) begin
               start      = 1'b1;
               first_addr = f + 5'd7;
               last_addr  = l + 5'd3;
               poked      = 1'b1;
            end
            out_ready = rdy;
            if (rdy) begin
               if (exp_q.size() != 0) void'(exp_q.pop_front());
               words++;
               prev_hold = 1'b0;
               gap       = 0;
            end else begin
               prev_hold = 1'b1;
               held      = obs_w;
            end
         end else begin
            gap++;
            out_ready = 1'($urandom_range(0, 1));
         end
         tick();
         start = 1'b0;
      end
      out_ready = 1'b0;
      check("done_count", 32'(dones), 32'd1);
      check("word_count", 32'(words), 32'(n));
   endtask

   initial begin
      reset      = 1'b1;
      start      = 1'b0;
      out_ready  = 1'b0;
      first_addr = '0;
      last_addr  = '0;
      for (int i = 0; i < 32; i++) mem[i] = 4'(i);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
      check("rst_addr", 32'(out_addr), 32'd0);
      check("rst_ram_addr", 32'(ram_address), 32'd0);
      check("rst_state", 32'(dbg_state), 32'd0);
      tick();
      tick();
      reset = 1'b0;
      tick();

      // identity contents, short sweep at full throughput
      do_sweep(5'd3, 5'd6, 100, 0, 0, 0);

      // inverted contents, wrapping sweep with random backpressure
      for (int i = 0; i < 32; i++) mem[i] = ~4'(i);
      do_sweep(5'd30, 5'd1, 60, 0, 0, 0);

      // single word, then the full 32-word ring
      mem[9] = 4'hA;
      do_sweep(5'd9, 5'd9, 100, 0, 0, 0);
      for (int i = 0; i < 32; i++) mem[i] = 4'($urandom_range(0, 15));
      do_sweep(5'd0, 5'd31, 70, 0, 0, 0);

      // consumer stalls the first word for 5 clocks
      do_sweep(5'd12, 5'd15, 100, 5, 0, 0);

      // start pulses mid-sweep and on the done cycle
      do_sweep(5'd20, 5'd24, 100, 0, 1, 1);

      // async reset while a word is presented
      first_addr = 5'd5;
      last_addr  = 5'd20;
      start      = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 10 && !out_valid; i++) tick();
      check("pre_reset_valid", 32'(out_valid), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("abort_valid", 32'(out_valid), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_ram_addr", 32'(ram_address), 32'd0);
      check("abort_state", 32'(dbg_state), 32'd0);
      #1 reset = 1'b0;
      tick();
      check("no_done_after_abort", 32'(done), 32'd0);
      check("idle_after_abort", 32'(busy), 32'd0);
      do_sweep(5'd0, 5'($urandom_range(0, 31)), 80, 0, 0, 0);

      // random sweeps over random contents
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 32; i++) mem[i] = 4'($urandom_range(0, 15));
         do_sweep(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 50 + 10 * k, 0, 0, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
